oled_spi_rx: RTL

- SPI receiver for the OLED display link: the receive end of the same 3-wire stream (SCLK, SDIN, D/C#) that the OLED driver transmits.
- Deserialises each byte, tags it as command or data, and buffers it in a FIFO.
- Exposes the buffer through a valid/ready read port.
- Used for on-board loopback of the display path (driver outputs wired back in, read port probed by ILA) and as the bench checker for the display driver.

---
 rtl/oled_spi_rx_if.sv | 18 +
 rtl/oled_spi_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_rx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : oled_spi_rx_if
// Brief    : Valid/ready read port of the OLED SPI receiver FIFO.
//            rd_data is {dc_n, byte[7:0]} of the FIFO head.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface oled_spi_rx_if;
   logic       rd_valid;
   logic [8:0] rd_data;
   logic       rd_ready;

   // Receiver side: presents the FIFO head, consumes ready
   modport master (output rd_valid, output rd_data, input rd_ready);
   // Consumer side
   modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface
`default_nettype wire

// File: rtl/oled_spi_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : oled_spi_rx
// Brief    : Receive end of the 3-wire OLED SPI link (SCLK, SDIN, D/C#).
//            Synchronises the link into clk, deserialises bytes MSB first,
//            tags them with D/C# and buffers them in a first-word-fall-
//            through FIFO read through a valid/ready port.
//            Optional build macro OLED_RX_CMD_ONLY_EN: only command bytes
//            (D/C# = 0) are pushed; data bytes are silently discarded.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module oled_spi_rx #(
   parameter int FIFO_DEPTH   = 16,
   parameter int IDLE_TIMEOUT = 1024,
   parameter int CNT_W        = 16
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             spi_clk,
   input  wire logic             spi_data,
   input  wire logic             spi_dc_n,
   input  wire logic             spi_reset_n,
   oled_spi_rx_if.master         rd,
   output logic                  overflow,
   input  wire logic             clr_ovf,
   output logic [CNT_W-1:0]      byte_count,
   output logic                  busy
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int TO_W   = $clog2(IDLE_TIMEOUT + 1);

`ifdef OLED_RX_CMD_ONLY_EN
   localparam logic CMD_ONLY = 1'b1;
`else
   localparam logic CMD_ONLY = 1'b0;
`endif

   // ---------------- synchroniser stage -------------------------------
   // Bit order in the packed sync vectors: {reset_n, dc_n, data, sclk}
   logic [3:0] sync1_d, sync1_q;
   logic [3:0] sync2_d, sync2_q;
   logic       sclk_s3_d, sclk_s3_q;

   logic sclk_s2, data_s2, dc_s2, rstn_s2;
   logic rise;

   // ---------------- receive state ------------------------------------
   logic [7:0]      shift_d, shift_q;
   logic [2:0]      bit_cnt_d, bit_cnt_q;
   logic [TO_W-1:0] to_cnt_d, to_cnt_q;
   logic            push_pend_d, push_pend_q;
   logic [8:0]      push_byte_d, push_byte_q;

   // ---------------- FIFO state ---------------------------------------
   logic [8:0]      mem_d [FIFO_DEPTH];
   logic [8:0]      mem_q [FIFO_DEPTH];
   logic [ADDR_W:0] wr_ptr_d, wr_ptr_q;
   logic [ADDR_W:0] rd_ptr_d, rd_ptr_q;
   logic [ADDR_W:0] fill;
   logic            empty, full, pop, push, drop;

   logic             overflow_d, overflow_q;
   logic [CNT_W-1:0] byte_count_d, byte_count_q;

   // Next value of the synchroniser chains
   always_comb begin
      sync1_d   = {spi_reset_n, spi_dc_n, spi_data, spi_clk};
      sync2_d   = sync1_q;
      sclk_s3_d = sync2_q[0];
   end

   assign sclk_s2 = sync2_q[0];
   assign data_s2 = sync2_q[1];
   assign dc_s2   = sync2_q[2];
   assign rstn_s2 = sync2_q[3];

   // SCLK rising edge, masked while the link is held in reset
   assign rise = sclk_s2 & ~sclk_s3_q & rstn_s2;

   // Deserialiser: shift on each rise, byte completes on the 8th rise,
   // partial byte dropped after an idle timeout or link reset
   always_comb begin
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      to_cnt_d    = to_cnt_q;
      push_pend_d = 1'b0;
      push_byte_d = push_byte_q;

      // Idle counter restarts on every rise and saturates at the timeout
      if (rise) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != TO_W'(IDLE_TIMEOUT)) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

      if (!rstn_s2) begin
         shift_d   = '0;
         bit_cnt_d = '0;
      end else if (rise) begin
         shift_d   = {shift_q[6:0], data_s2};
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            push_byte_d = {dc_s2, shift_q[6:0], data_s2};
            push_pend_d = CMD_ONLY ? ~dc_s2 : 1'b1;
         end
      end else if ((to_cnt_q == TO_W'(IDLE_TIMEOUT)) && (bit_cnt_q != 3'd0)) begin
         shift_d   = '0;
         bit_cnt_d = '0;
      end
   end

   // FIFO control: push/pop arbitration, overflow and byte counter
   always_comb begin
      fill  = wr_ptr_q - rd_ptr_q;
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (fill == (ADDR_W+1)'(FIFO_DEPTH));
      pop   = ~empty & rd.rd_ready;
      // A pop in the same cycle frees a slot, so a full FIFO still accepts
      push  = push_pend_q & (~full | pop);
      drop  = push_pend_q & full & ~pop;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[ADDR_W-1:0]] = push_byte_q;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      // A new overflow wins over a simultaneous clear
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end

      byte_count_d = byte_count_q;
      if (push) begin
         byte_count_d = byte_count_q + 1'b1;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 4'b0001;   // SCLK idles high: no false edge out of reset
         sync2_q      <= 4'b0001;
         sclk_s3_q    <= 1'b1;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         to_cnt_q     <= '0;
         push_pend_q  <= 1'b0;
         push_byte_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         byte_count_q <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         sclk_s3_q    <= sclk_s3_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         to_cnt_q     <= to_cnt_d;
         push_pend_q  <= push_pend_d;
         push_byte_q  <= push_byte_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
         byte_count_q <= byte_count_d;
      end
   end

   // FIFO storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd.rd_valid = ~empty;
   assign rd.rd_data  = empty ? 9'h000 : mem_q[rd_ptr_q[ADDR_W-1:0]];
   assign overflow    = overflow_q;
   assign byte_count  = byte_count_q;
   assign busy        = (bit_cnt_q != 3'd0);

endmodule
`default_nettype wire
